// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin, burst-locked arbiter sharing one async-FIFO write port among
//   NREQ requesters. Lives in the FIFO write clock domain. One requester owns
//   the port per burst; its beats are forwarded as registered wr_en/wr_data.
//   A burst ends on req_last or after MAXBURST beats, and the next grant
//   rotates round-robin starting after the previous owner.
// Ports
//   clk, rst_n   write-domain clock, async active-low reset
//   req_valid    per-requester beat valid
//   req_last     per-requester last beat of packet (sampled with valid)
//   req_data     requester i data at [i*DBITS +: DBITS]
//   req_ready    per-requester accept; only the owner can be ready
//   grant        one-hot owner, zero when idle
//   busy         high while a burst is in progress
//   wr_full      FIFO full flag (backpressure)
//   wr_en        registered FIFO write strobe
//   wr_data      registered FIFO write data
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DBITS    = 16,
  parameter int MAXBURST = 16,
  parameter int CBITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DBITS-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  input  logic                  wr_full,
  output logic                  wr_en,
  output logic [DBITS-1:0]      wr_data
);

  localparam int IBITS = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                           state_q;
  logic [NREQ-1:0]                  grant_q;
  logic [IBITS-1:0]                 gidx_q;
  logic [IBITS-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [CBITS-1:0]                 beat_cnt_q, beat_cnt_d;
  logic                             busy_q;
  logic                             wr_en_q;
  logic [DBITS-1:0]                 wr_data_q;

  logic [NREQ-1:0][DBITS-1:0]       req_data_a;
  logic                             pick_found;
  logic [IBITS-1:0]                 pick_idx, cand;
  logic                             accept, burst_end;

  assign req_data_a = req_data;

  // Round-robin scan: first valid requester at rr_ptr, rr_ptr+1, ... mod NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IBITS'((int'(rr_ptr_q) + k) % NREQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Owner-only ready; wr_full gates acceptance in the same cycle so the one
  // in-flight registered write is the only thing that can land after full.
  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign req_ready[i] = busy_q & grant_q[i] & ~wr_full;
  end

  assign accept     = busy_q & req_valid[gidx_q] & ~wr_full;
  // Truncation at MAXBURST ends the grant without consuming req_last.
  assign burst_end  = req_last[gidx_q] | (beat_cnt_q == CBITS'(MAXBURST - 1));
  assign rr_ptr_d   = (gidx_q == IBITS'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
  assign beat_cnt_d = beat_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_en_q <= 1'b0;
          if (pick_found) begin
            state_q    <= BURST;
            busy_q     <= 1'b1;
            gidx_q     <= pick_idx;
            grant_q    <= NREQ'(1) << pick_idx;
            beat_cnt_q <= '0;
          end
        end
        BURST: begin
          // A missing valid is a bubble: grant stays, nothing is written.
          wr_en_q <= accept;
          if (accept) begin
            wr_data_q <= req_data_a[gidx_q];
            if (burst_end) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              grant_q    <= '0;
              beat_cnt_q <= '0;
              rr_ptr_q   <= rr_ptr_d;
            end else begin
              beat_cnt_q <= beat_cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter. Requesters are packet queues; a
// transaction-level model (owner index, rotating pointer, beat count) decides
// each cycle which beat should be taken and pushes its data into a scoreboard
// that a separate monitor drains on every wr_en.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DBITS = 16, MAXBURST = 16, CBITS = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid, req_last, req_ready, grant;
  logic [NREQ*DBITS-1:0] req_data;
  logic                  busy, wr_full, wr_en;
  logic [DBITS-1:0]      wr_data;

  fifo_wr_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .MAXBURST(MAXBURST), .CBITS(CBITS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .grant(grant), .busy(busy),
    .wr_full(wr_full), .wr_en(wr_en), .wr_data(wr_data));

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  // Requester packet queues: bit DBITS = last flag.
  logic [DBITS:0]   srcq[NREQ][$];
  logic [DBITS-1:0] expq[$];
  int seqn[NREQ];

  // Reference model state.
  int owner = -1, ptr = 0, cnt = 0;
  bit exp_wen = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add_pkt(int i, int len);
    for (int b = 0; b < len; b++) begin
      srcq[i].push_back({1'(b == len - 1), 4'(i), 12'(seqn[i])});
      seqn[i]++;
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL wr_unexpected: got write %0h expected none", wr_data);
      end else begin
        chk("wr_data", 64'(wr_data), 64'(expq.pop_front()));
      end
    end
  end

  task automatic model_step();
    bit found = 0;
    logic [DBITS:0] beat;
    exp_wen = 0;
    if (owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j = (ptr + k) % NREQ;
        if (!found && req_valid[j]) begin found = 1; owner = j; cnt = 0; end
      end
    end else if (req_valid[owner] && !wr_full) begin
      beat = srcq[owner].pop_front();
      expq.push_back(beat[DBITS-1:0]);
      exp_wen = 1;
      if (beat[DBITS] || cnt == MAXBURST - 1) begin
        ptr = (owner + 1) % NREQ; owner = -1; cnt = 0;
      end else cnt++;
    end
  endtask

  task automatic run_cycles(int n, int vprob, int fprob, bit refill);
    logic [NREQ-1:0] eg, er;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      eg = (owner >= 0) ? (NREQ'(1) << owner) : '0;
      chk("grant", 64'(grant), 64'(eg));
      chk("busy", 64'(busy), 64'(owner >= 0));
      chk("wr_en", 64'(wr_en), 64'(exp_wen));
      for (int i = 0; i < NREQ; i++) begin
        if (refill && srcq[i].size() < 4) add_pkt(i, $urandom_range(20, 1));
        if (srcq[i].size() > 0 && $urandom_range(99) < vprob) begin
          req_valid[i] = 1'b1;
          req_last[i]  = srcq[i][0][DBITS];
          req_data[i*DBITS +: DBITS] = srcq[i][0][DBITS-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          req_data[i*DBITS +: DBITS] = '0;
        end
      end
      wr_full = ($urandom_range(99) < fprob);
      #1;
      for (int i = 0; i < NREQ; i++) er[i] = (owner == i) && !wr_full;
      chk("req_ready", 64'(req_ready), 64'(er));
      model_step();
    end
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_last = '0; req_data = '0; wr_full = 1'b0;
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    clear_inputs();
    for (int i = 0; i < NREQ; i++) seqn[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    rst_n = 1'b1;

    // Single 3-beat packet from req0.
    add_pkt(0, 3);
    run_cycles(10, 100, 0, 0);
    chk("rr_after_req0", 64'(ptr), 64'(1));
    // Everyone with 2-beat packets: rotation 1,2,3,0,...
    for (int i = 0; i < NREQ; i++) begin add_pkt(i, 2); add_pkt(i, 2); end
    run_cycles(40, 100, 0, 0);
    // Long packet truncated at MAXBURST with a competitor waiting.
    add_pkt(1, 20); add_pkt(2, 3);
    run_cycles(40, 100, 0, 0);
    // Long 8-beat burst with heavy backpressure.
    add_pkt(3, 8);
    run_cycles(30, 100, 50, 0);
    // Random traffic, backpressure and bubbles.
    run_cycles(1500, 80, 30, 1);
    run_cycles(500, 50, 0, 1);

    // Reset in the middle of a burst.
    hit = 0;
    for (int t = 0; t < 500 && !hit; t++) begin
      if (owner >= 0 && cnt == 3) hit = 1;
      else run_cycles(1, 100, 0, 1);
    end
    if (!hit) begin total++; $display("FAIL mid_burst_wait: got timeout expected burst"); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_grant", 64'(grant), 64'(0));
    chk("rst2_busy", 64'(busy), 64'(0));
    chk("rst2_wr_en", 64'(wr_en), 64'(0));
    chk("rst2_wr_data", 64'(wr_data), 64'(0));
    chk("rst2_ready", 64'(req_ready), 64'(0));
    owner = -1; ptr = 0; cnt = 0; exp_wen = 0;
    expq.delete();
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(2, 3); add_pkt(0, 3);
    run_cycles(20, 100, 0, 0);

    // Drain whatever is left.
    hit = 0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      if (owner < 0 && srcq[0].size() == 0 && srcq[1].size() == 0 &&
          srcq[2].size() == 0 && srcq[3].size() == 0) hit = 1;
      else run_cycles(1, 100, 0, 0);
    end
    if (!hit) begin total++; $display("FAIL drain: got timeout expected empty queues"); end
    run_cycles(3, 100, 0, 0);
    chk("scoreboard_empty", 64'(expq.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
